datapath_micro: RTL and testbench

- 8-bit execution datapath driven by the control unit's decoded control word (Sel_op, Sel_reg, W, Sel_outbus, Sel_DW).
- Returns Rx (jump-condition operand) and Ban (ALU flags) to the control unit.
- Contains an 8-entry register file, operand-B mux, ALU, synchronized input port and four registered output ports.
- Sits between the control unit and the board I/O; single-cycle execution, one control word per clk.

---
 rtl/datapath_micro.sv | 121 ++++++++++++
 tb/tb_datapath_micro.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_micro.sv
// datapath_micro: 8-bit execution datapath driven by the decoded control word.
// Contains an 8-entry register file, operand-B mux, ALU, a synchronized input
// port and four registered output ports.
// Optional build macro: DATAPATH_CARRY_EN
//   defined   -> carry register cy; Sel_op 110 = ADC, 111 = SBB (no shifts)
//   undefined -> Sel_op 110 = SHL, 111 = SHR
module datapath_micro #(
    parameter int NREG             = 8,
    parameter int PORT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  Sel_op,
    input  logic [5:0]  Sel_reg,
    input  logic        W,
    input  logic [1:0]  Sel_outbus,
    input  logic [2:0]  Sel_DW,
    input  logic [7:0]  i_inmediato,
    input  logic [7:0]  i_port_in,
    output logic [7:0]  Rx,
    output logic [2:0]  Ban,
    output logic [7:0]  o_bus,
    output logic [31:0] o_puertos
);

    logic [7:0] regs   [NREG];
    logic [7:0] sync_q [PORT_SYNC_STAGES];
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
    logic       carry;
    // bit 8 carries C/borrow; bits 7:0 are the result
    logic [8:0] wide;

`ifdef DATAPATH_CARRY_EN
    logic       cy;
`endif

    // operand selection; reads see pre-write register contents
    always_comb begin
        op_a = regs[Sel_reg[5:3]];
        op_b = 8'h00;
        case (Sel_outbus)
            2'b00:   op_b = regs[Sel_reg[2:0]];
            2'b01:   op_b = i_inmediato;
            2'b10:   op_b = sync_q[PORT_SYNC_STAGES-1];
            default: op_b = 8'h00;
        endcase
    end

    // ALU: every op is folded into a 9-bit word so C is always wide[8]
    always_comb begin
        wide = 9'h000;
        case (Sel_op)
            3'b000: wide = {1'b0, op_a} + {1'b0, op_b};
            3'b001: wide = {1'b0, op_a} - {1'b0, op_b};
            3'b010: wide = {1'b0, op_a & op_b};
            3'b011: wide = {1'b0, op_a | op_b};
            3'b100: wide = {1'b0, op_a ^ op_b};
            3'b101: wide = {1'b0, op_b};
`ifdef DATAPATH_CARRY_EN
            3'b110: wide = {1'b0, op_a} + {1'b0, op_b} + {8'h00, cy};
            default: wide = {1'b0, op_a} - {1'b0, op_b} - {8'h00, cy};
`else
            3'b110: wide = {op_a, 1'b0};
            default: wide = {op_a[0], 1'b0, op_a[7:1]};
`endif
        endcase
        result = wide[7:0];
        carry  = wide[8];
    end

    // outputs back to the control unit and observation bus
    always_comb begin
        Rx    = op_a;
        o_bus = result;
        Ban   = {carry, (result == 8'h00), result[7]};
    end

    // register file write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else if (W) begin
            regs[Sel_reg[5:3]] <= result;
        end
    end

    // input port synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORT_SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else begin
            sync_q[0] <= i_port_in;
            for (int i = 1; i < PORT_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // output ports capture operand A (old value even if it is being written)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_puertos <= 32'h0000_0000;
        end else if (Sel_DW[2]) begin
            case (Sel_DW[1:0])
                2'd0:    o_puertos[7:0]   <= op_a;
                2'd1:    o_puertos[15:8]  <= op_a;
                2'd2:    o_puertos[23:16] <= op_a;
                default: o_puertos[31:24] <= op_a;
            endcase
        end
    end

`ifdef DATAPATH_CARRY_EN
    // carry register follows C whenever a result is written back
    always_ff @(posedge clk or posedge rst) begin
        if (rst)    cy <= 1'b0;
        else if (W) cy <= carry;
    end
`endif

endmodule

// File: tb/tb_datapath_micro.sv
// Testbench for datapath_micro: directed scenarios plus randomized control
// words, checked against an arithmetic reference model.
module tb_datapath_micro;

    localparam int SYNC = 2;

    logic        clk;
    logic        rst;
    logic [2:0]  Sel_op;
    logic [5:0]  Sel_reg;
    logic        W;
    logic [1:0]  Sel_outbus;
    logic [2:0]  Sel_DW;
    logic [7:0]  i_inmediato;
    logic [7:0]  i_port_in;
    logic [7:0]  Rx;
    logic [2:0]  Ban;
    logic [7:0]  o_bus;
    logic [31:0] o_puertos;

    datapath_micro #(.NREG(8), .PORT_SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .Sel_op(Sel_op), .Sel_reg(Sel_reg), .W(W),
        .Sel_outbus(Sel_outbus), .Sel_DW(Sel_DW), .i_inmediato(i_inmediato),
        .i_port_in(i_port_in), .Rx(Rx), .Ban(Ban), .o_bus(o_bus),
        .o_puertos(o_puertos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int mreg [8];
    int mport [4];
    int mcy;
    int syncq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        for (int i = 0; i < 4; i++) mport[i] = 0;
        mcy = 0;
        syncq.delete();
        for (int i = 0; i < SYNC; i++) syncq.push_back(0);
    endtask

    task automatic model_alu(input int a, input int b, output int r, output int c);
        r = 0;
        c = 0;
        case (Sel_op)
            3'd0: begin r = (a + b) % 256; c = (a + b > 255); end
            3'd1: begin r = (a - b + 256) % 256; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
`ifdef DATAPATH_CARRY_EN
            3'd6: begin r = (a + b + mcy) % 256; c = (a + b + mcy > 255); end
            default: begin r = (a - b - mcy + 512) % 256; c = (a < b + mcy); end
`else
            3'd6: begin r = (a * 2) % 256; c = (a >= 128); end
            default: begin r = a / 2; c = a % 2; end
`endif
        endcase
    endtask

    function automatic logic [31:0] exp_ports();
        return {mport[3][7:0], mport[2][7:0], mport[1][7:0], mport[0][7:0]};
    endfunction

    // one clock: check combinational outputs before the edge, then update model at the edge
    task automatic cycle();
        int a, b, r, c, ban;
        @(negedge clk);
        a = mreg[Sel_reg[5:3]];
        case (Sel_outbus)
            2'b00:   b = mreg[Sel_reg[2:0]];
            2'b01:   b = int'(i_inmediato);
            2'b10:   b = syncq[SYNC-1];
            default: b = 0;
        endcase
        model_alu(a, b, r, c);
        ban = c * 4 + ((r == 0) ? 2 : 0) + ((r >= 128) ? 1 : 0);
        check_val("rx", {24'h0, Rx}, a);
        check_val("bus", {24'h0, o_bus}, r);
        check_val("ban", {29'h0, Ban}, ban);
        check_val("ports", o_puertos, exp_ports());
        @(posedge clk);
        if (Sel_DW[2]) mport[Sel_DW[1:0]] = a;
        if (W) begin
            mreg[Sel_reg[5:3]] = r;
            mcy = c;
        end
        syncq.push_front(int'(i_port_in));
        void'(syncq.pop_back());
        #1;
    endtask

    task automatic set_cw(input logic [2:0] op, input int rd, input int rs, input logic w,
                          input logic [1:0] ob, input logic [2:0] dw, input logic [7:0] imm);
        Sel_op      = op;
        Sel_reg     = {rd[2:0], rs[2:0]};
        W           = w;
        Sel_outbus  = ob;
        Sel_DW      = dw;
        i_inmediato = imm;
        #1;
    endtask

    task automatic mid_reset();
        set_cw(3'd0, 3, 1, 1'b1, 2'b11, 3'b101, 8'h00);
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_rx", {24'h0, Rx}, 0);
        check_val("rst_ports", o_puertos, 0);
        check_val("rst_ban", {29'h0, Ban}, 3'b010);
        check_val("rst_bus", {24'h0, o_bus}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_port_in = 8'h00;
        set_cw(3'd0, 0, 0, 1'b0, 2'b11, 3'b000, 8'h00);
        model_reset();
        check_val("init_rx", {24'h0, Rx}, 0);
        check_val("init_ban", {29'h0, Ban}, 3'b010);
        check_val("init_ports", o_puertos, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // load and add
        set_cw(3'd5, 1, 0, 1'b1, 2'b01, 3'b000, 8'hF0); cycle();
        set_cw(3'd5, 2, 0, 1'b1, 2'b01, 3'b000, 8'h20); cycle();
        set_cw(3'd0, 1, 2, 1'b1, 2'b00, 3'b000, 8'h00);
        check_val("add_bus", {24'h0, o_bus}, 8'h10);
        check_val("add_ban", {29'h0, Ban}, 3'b100);
        cycle();
        set_cw(3'd5, 1, 0, 1'b0, 2'b11, 3'b000, 8'h00);
        check_val("add_wb", {24'h0, Rx}, 8'h10);

        // subtract and compare
        set_cw(3'd5, 3, 0, 1'b1, 2'b01, 3'b000, 8'h05); cycle();
        set_cw(3'd1, 3, 0, 1'b0, 2'b01, 3'b000, 8'h05);
        check_val("sub_eq_ban", {29'h0, Ban}, 3'b010);
        cycle();
        set_cw(3'd1, 3, 0, 1'b0, 2'b01, 3'b000, 8'h06);
        check_val("sub_lt_bus", {24'h0, o_bus}, 8'hFF);
        check_val("sub_lt_ban", {29'h0, Ban}, 3'b101);
        cycle();

`ifndef DATAPATH_CARRY_EN
        // port write while the same register is written back
        set_cw(3'd5, 4, 0, 1'b1, 2'b01, 3'b000, 8'h5A); cycle();
        set_cw(3'd6, 4, 0, 1'b1, 2'b11, 3'b110, 8'h00);
        check_val("shl_bus", {24'h0, o_bus}, 8'hB4);
        check_val("shl_ban", {29'h0, Ban}, 3'b001);
        cycle();
        check_val("port2", o_puertos, 32'h005A_0000);
        set_cw(3'd5, 4, 0, 1'b0, 2'b11, 3'b000, 8'h00);
        check_val("shl_wb", {24'h0, Rx}, 8'hB4);
`else
        // carry chain through cy
        set_cw(3'd5, 0, 0, 1'b1, 2'b01, 3'b000, 8'hFF); cycle();
        set_cw(3'd0, 0, 0, 1'b1, 2'b01, 3'b000, 8'h01); cycle();
        set_cw(3'd6, 0, 0, 1'b0, 2'b11, 3'b000, 8'h00);
        check_val("adc_bus", {24'h0, o_bus}, 8'h01);
        check_val("adc_ban", {29'h0, Ban}, 3'b000);
        cycle();
`endif

        // input synchronizer latency
        set_cw(3'd5, 0, 0, 1'b0, 2'b10, 3'b000, 8'h00);
        for (int i = 0; i < SYNC + 1; i++) cycle();
        i_port_in = 8'h3C;
        check_val("sync_0edge", {24'h0, o_bus}, 8'h00);
        for (int i = 1; i <= SYNC; i++) begin
            cycle();
            check_val("sync_edge", {24'h0, o_bus}, (i == SYNC) ? 8'h3C : 8'h00);
        end

        // randomized control words
        for (int n = 0; n < 400; n++) begin
            set_cw(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) i_port_in = 8'($urandom);
            cycle();
            if (n == 200) begin
                mid_reset();
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
